// File: rtl/ins_fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetches to instruction memory,
// tracks in-flight requests, queues returned words with their addresses and
// squashes stale responses after a datapath redirect.
module ins_fetch_unit #(
    parameter logic [31:0] START_INS_ADDRESS = 32'h0000_0000,
    parameter int unsigned DEPTH             = 4
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ins_valid,
    output logic [31:0] instruction,
    output logic [31:0] PC,
    input  logic        ins_ready,
    output logic        fetch_misaligned
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]      fetch_pc, fetch_pc_n;
    logic [CNT_W-1:0] outstanding, outstanding_n;
    logic [CNT_W-1:0] discard, discard_n;
    logic [CNT_W-1:0] occupancy, occupancy_n;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_n;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_n;

    logic [31:0] q_data [DEPTH];
    logic [31:0] q_pc   [DEPTH];

    logic        req_hs;
    logic        deq;
    logic        rsp_ok;
    logic        enq;
    logic [31:0] rsp_pc;
    logic [SUM_W-1:0] inflight;
    logic        head_hit;
    logic [31:0] head_data_n;
    logic [31:0] head_pc_n;

    // Request credit: queued plus in-flight words must fit in the queue
    assign inflight       = SUM_W'(occupancy) + SUM_W'(outstanding);
    assign imem_req_valid = SYS_reset && (inflight < SUM_W'(DEPTH));
    assign imem_req_addr  = fetch_pc;

    assign req_hs = imem_req_valid && imem_req_ready;
    assign deq    = ins_valid && ins_ready;
    assign rsp_ok = imem_rsp_valid && (outstanding != '0);
    assign enq    = rsp_ok && (discard == '0) && !redirect_valid;

    // With no stale requests pending, the oldest in-flight fetch sits
    // 'outstanding' words behind fetch_pc
    assign rsp_pc = fetch_pc - 32'({outstanding, 2'b00});

    // Next-state for fetch pointer, counters and queue pointers
    always_comb begin
        fetch_pc_n    = fetch_pc;
        outstanding_n = outstanding;
        discard_n     = discard;
        occupancy_n   = occupancy;
        rd_ptr_n      = rd_ptr;
        wr_ptr_n      = wr_ptr;

        if (req_hs) begin
            fetch_pc_n    = fetch_pc + 32'd4;
            outstanding_n = outstanding + CNT_W'(1);
        end
        if (rsp_ok) begin
            outstanding_n = outstanding_n - CNT_W'(1);
            if (discard != '0) begin
                discard_n = discard - CNT_W'(1);
            end
        end
        if (enq) begin
            wr_ptr_n = wr_ptr + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_n = rd_ptr + PTR_W'(1);
        end
        occupancy_n = occupancy + CNT_W'(enq) - CNT_W'(deq);

        // Redirect overrides everything; every fetch still in flight is stale
        if (redirect_valid) begin
            fetch_pc_n  = {redirect_pc[31:2], 2'b00};
            occupancy_n = '0;
            discard_n   = outstanding_n;
            rd_ptr_n    = '0;
            wr_ptr_n    = '0;
        end
    end

    // Next head entry, taken straight from the response when it lands at the head
    always_comb begin
        head_hit    = enq && (wr_ptr == rd_ptr_n);
        head_data_n = q_data[rd_ptr_n];
        head_pc_n   = q_pc[rd_ptr_n];
        if (head_hit) begin
            head_data_n = imem_rsp_data;
            head_pc_n   = rsp_pc;
        end
    end

    // Control state and registered outputs
    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            fetch_pc         <= START_INS_ADDRESS;
            outstanding      <= '0;
            discard          <= '0;
            occupancy        <= '0;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            ins_valid        <= 1'b0;
            instruction      <= '0;
            PC               <= '0;
            fetch_misaligned <= 1'b0;
        end else begin
            fetch_pc         <= fetch_pc_n;
            outstanding      <= outstanding_n;
            discard          <= discard_n;
            occupancy        <= occupancy_n;
            rd_ptr           <= rd_ptr_n;
            wr_ptr           <= wr_ptr_n;
            ins_valid        <= (occupancy_n != '0);
            fetch_misaligned <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (occupancy_n != '0) begin
                instruction <= head_data_n;
                PC          <= head_pc_n;
            end
        end
    end

    // Queue storage; contents are only read once written, so no reset
    always_ff @(posedge SYS_clk) begin
        if (enq) begin
            q_data[wr_ptr] <= imem_rsp_data;
            q_pc[wr_ptr]   <= rsp_pc;
        end
    end

endmodule
